dram_rd_arb: RTL and testbench
==============================

DRAM_RD_ARB -- requirements
Module: dram_rd_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the AXI read address width.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 SHALL have port lsu_arb_arvld, input, 1 bit: LSU read request valid.
REQ-005 SHALL have port lsu_arb_ar{id,addr,len,size,burst}, inputs, 8/ADDR_W/8/3/2 bits: LSU AR payload.
REQ-006 SHALL have port arb_lsu_arrdy, output, 1 bit: LSU request accepted.
REQ-007 SHALL have ports ifu_arb_arvld, ifu_arb_ar{id,addr,len,size,burst} and arb_ifu_arrdy, same directions and widths as REQ-004..006: IFU requester.
REQ-008 SHALL have ports arb_{lsu,ifu}_r{vld,data,resp,last,id}, outputs, 1/64/2/1/8 bits: routed R beats.
REQ-009 SHALL have ports {lsu,ifu}_arb_rrdy, inputs, 1 bit: requester R ready.
REQ-010 SHALL have ports arb_axi_ar{vld,id,addr,len,size,burst}, outputs, 1/8/ADDR_W/8/3/2 bits, plus axi_arb_arrdy, input, 1 bit: shared AR channel.
REQ-011 SHALL have ports axi_arb_r{vld,data,resp,last,id}, inputs, 1/64/2/1/8 bits, plus arb_axi_rrdy, output, 1 bit: shared R channel.
REQ-012 SHALL have ports arb_busy, output, 1 bit (state not IDLE), and arb_len_err, output, 1 bit (sticky beat-count mismatch).

Function
REQ-013 SHALL implement states IDLE, ADDR and DATA, with at most one burst outstanding.
REQ-014 SHALL, in IDLE, grant one valid requester: if one is valid, grant it; if both are valid, grant the one not recorded in last_gnt.
REQ-015 SHALL assert the granted requester's arrdy combinationally in the grant cycle, latch its payload and owner, and go to ADDR.
REQ-016 SHALL drive arb_axi_arvld from the latched payload starting the cycle after grant (one cycle of latency), holding it and the payload stable until axi_arb_arrdy is high, then go to DATA.
REQ-017 SHALL, in DATA, connect arb_axi_rrdy to the owner's rrdy and the owner's r* outputs to axi_arb_r*, and hold the non-owner's rvld at 0.
REQ-018 SHALL count accepted beats (rvld and rrdy), starting from 0 on each grant, with a 9-bit counter.
REQ-019 SHALL, on an accepted beat with rlast, go to IDLE, update last_gnt to the owner, and set arb_len_err if the beat count is not len+1.
REQ-020 SHALL hold arb_axi_rrdy at 0 in IDLE and ADDR, so R beats arriving there are not accepted.
REQ-021 SHALL assert arrdy to neither requester outside IDLE; a request raised during a burst waits.
REQ-022 SHALL let a requester that deasserts arvld before grant lose nothing: no state change occurs.
REQ-023 SHALL grant one requester per IDLE cycle at most, so back-to-back bursts have at least one IDLE cycle between them.

Reset
REQ-024 SHALL on reset set state to IDLE, all vld/rdy outputs to 0, payload outputs to 0, beat counter to 0, arb_len_err to 0, and last_gnt to IFU so that LSU wins the first tie.
REQ-025 SHALL, on reset mid-burst, abandon the burst with no replay; arb_busy goes to 0 while reset is low.

Configuration
REQ-026 SHALL, when macro DRAM_RD_ARB_LSU_PRIO_EN is defined, use fixed priority with LSU always winning ties and last_gnt unused; when it is undefined, use round-robin as in REQ-014.

Verification
REQ-027 Single LSU request with addr=0x040, len=3, arrdy always 1 -> arb_lsu_arrdy high in cycle 0, arb_axi_arvld in cycle 1, 4 beats routed to LSU, arb_busy falls after rlast, arb_len_err=0.
REQ-028 LSU and IFU both valid from reset, each with len=0 -> LSU granted first, IFU granted in the next IDLE; with DRAM_RD_ARB_LSU_PRIO_EN and LSU re-requesting, LSU is granted again.
REQ-029 axi_arb_arrdy held low for 5 cycles -> arb_axi_arvld and payload stable for 6 cycles; then DATA.
REQ-030 len=1 but rlast on beat 3 -> arb_len_err set and remaining 1 until reset; state returns to IDLE.
REQ-031 Owner rrdy toggles 0/1 during 4 beats -> arb_axi_rrdy mirrors it, no beat lost or duplicated, non-owner rvld stays 0.
REQ-032 rst_n pulled low during DATA beat 2 -> all outputs 0 asynchronously, IDLE after release, next LSU request served normally.

Source files
------------

// File: rtl/dram_rd_arb_if.sv
// Requester AR/R ports plus the shared AXI AR/R channel of dram_rd_arb.
// slave: arbiter view; master: environment (requesters + AXI slave) view.
interface dram_rd_arb_if #(
  parameter int ADDR_W = 10
);
  logic              lsu_arb_arvld;
  logic [7:0]        lsu_arb_arid;
  logic [ADDR_W-1:0] lsu_arb_araddr;
  logic [7:0]        lsu_arb_arlen;
  logic [2:0]        lsu_arb_arsize;
  logic [1:0]        lsu_arb_arburst;
  logic              arb_lsu_arrdy;
  logic              arb_lsu_rvld;
  logic [63:0]       arb_lsu_rdata;
  logic [1:0]        arb_lsu_rresp;
  logic              arb_lsu_rlast;
  logic [7:0]        arb_lsu_rid;
  logic              lsu_arb_rrdy;

  logic              ifu_arb_arvld;
  logic [7:0]        ifu_arb_arid;
  logic [ADDR_W-1:0] ifu_arb_araddr;
  logic [7:0]        ifu_arb_arlen;
  logic [2:0]        ifu_arb_arsize;
  logic [1:0]        ifu_arb_arburst;
  logic              arb_ifu_arrdy;
  logic              arb_ifu_rvld;
  logic [63:0]       arb_ifu_rdata;
  logic [1:0]        arb_ifu_rresp;
  logic              arb_ifu_rlast;
  logic [7:0]        arb_ifu_rid;
  logic              ifu_arb_rrdy;

  logic              arb_axi_arvld;
  logic [7:0]        arb_axi_arid;
  logic [ADDR_W-1:0] arb_axi_araddr;
  logic [7:0]        arb_axi_arlen;
  logic [2:0]        arb_axi_arsize;
  logic [1:0]        arb_axi_arburst;
  logic              axi_arb_arrdy;
  logic              axi_arb_rvld;
  logic [63:0]       axi_arb_rdata;
  logic [1:0]        axi_arb_rresp;
  logic              axi_arb_rlast;
  logic [7:0]        axi_arb_rid;
  logic              arb_axi_rrdy;

  logic              arb_busy;
  logic              arb_len_err;

  modport slave (
    input  lsu_arb_arvld, lsu_arb_arid, lsu_arb_araddr, lsu_arb_arlen, lsu_arb_arsize,
           lsu_arb_arburst, lsu_arb_rrdy,
    output arb_lsu_arrdy, arb_lsu_rvld, arb_lsu_rdata, arb_lsu_rresp, arb_lsu_rlast, arb_lsu_rid,
    input  ifu_arb_arvld, ifu_arb_arid, ifu_arb_araddr, ifu_arb_arlen, ifu_arb_arsize,
           ifu_arb_arburst, ifu_arb_rrdy,
    output arb_ifu_arrdy, arb_ifu_rvld, arb_ifu_rdata, arb_ifu_rresp, arb_ifu_rlast, arb_ifu_rid,
    output arb_axi_arvld, arb_axi_arid, arb_axi_araddr, arb_axi_arlen, arb_axi_arsize,
           arb_axi_arburst, arb_axi_rrdy,
    input  axi_arb_arrdy, axi_arb_rvld, axi_arb_rdata, axi_arb_rresp, axi_arb_rlast, axi_arb_rid,
    output arb_busy, arb_len_err
  );

  modport master (
    output lsu_arb_arvld, lsu_arb_arid, lsu_arb_araddr, lsu_arb_arlen, lsu_arb_arsize,
           lsu_arb_arburst, lsu_arb_rrdy,
    input  arb_lsu_arrdy, arb_lsu_rvld, arb_lsu_rdata, arb_lsu_rresp, arb_lsu_rlast, arb_lsu_rid,
    output ifu_arb_arvld, ifu_arb_arid, ifu_arb_araddr, ifu_arb_arlen, ifu_arb_arsize,
           ifu_arb_arburst, ifu_arb_rrdy,
    input  arb_ifu_arrdy, arb_ifu_rvld, arb_ifu_rdata, arb_ifu_rresp, arb_ifu_rlast, arb_ifu_rid,
    input  arb_axi_arvld, arb_axi_arid, arb_axi_araddr, arb_axi_arlen, arb_axi_arsize,
           arb_axi_arburst, arb_axi_rrdy,
    output axi_arb_arrdy, axi_arb_rvld, axi_arb_rdata, axi_arb_rresp, axi_arb_rlast, axi_arb_rid,
    input  arb_busy, arb_len_err
  );
endinterface

// File: rtl/dram_rd_arb.sv
// Two-requester (LSU/IFU) AXI read arbiter, one burst outstanding, round-robin ties.
// Define DRAM_RD_ARB_LSU_PRIO_EN for fixed priority with LSU winning every tie.
module dram_rd_arb #(
  parameter int ADDR_W = 10
) (
  input logic           clk,
  input logic           rst_n,
  dram_rd_arb_if.slave  bus
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic OWN_LSU = 1'b0;
  localparam logic OWN_IFU = 1'b1;

  state_e            state_r;
  logic              owner_r;
  logic [8:0]        beat_cnt_r;
  logic              len_err_r;
  logic              arvld_r;
  logic [7:0]        arid_r;
  logic [ADDR_W-1:0] araddr_r;
  logic [7:0]        arlen_r;
  logic [2:0]        arsize_r;
  logic [1:0]        arburst_r;
`ifndef DRAM_RD_ARB_LSU_PRIO_EN
  logic              last_gnt_r;
`endif

  logic              lsu_win_s;
  logic              gnt_lsu_s;
  logic              gnt_ifu_s;
  logic [7:0]        sel_id_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [7:0]        sel_len_s;
  logic [2:0]        sel_size_s;
  logic [1:0]        sel_burst_s;
  logic              own_lsu_s;
  logic              own_ifu_s;
  logic              rrdy_s;
  logic              beat_acc_s;
  logic [8:0]        beat_nxt_s;

  // Grant decision and payload selection; arrdy is forced low while reset is asserted.
  always_comb begin
`ifdef DRAM_RD_ARB_LSU_PRIO_EN
    lsu_win_s = bus.lsu_arb_arvld;
`else
    lsu_win_s = bus.lsu_arb_arvld && (!bus.ifu_arb_arvld || (last_gnt_r == OWN_IFU));
`endif
    if (rst_n && (state_r == ST_IDLE)) begin
      gnt_lsu_s = lsu_win_s;
      gnt_ifu_s = bus.ifu_arb_arvld && !lsu_win_s;
    end else begin
      gnt_lsu_s = 1'b0;
      gnt_ifu_s = 1'b0;
    end
    if (gnt_ifu_s) begin
      sel_id_s    = bus.ifu_arb_arid;
      sel_addr_s  = bus.ifu_arb_araddr;
      sel_len_s   = bus.ifu_arb_arlen;
      sel_size_s  = bus.ifu_arb_arsize;
      sel_burst_s = bus.ifu_arb_arburst;
    end else begin
      sel_id_s    = bus.lsu_arb_arid;
      sel_addr_s  = bus.lsu_arb_araddr;
      sel_len_s   = bus.lsu_arb_arlen;
      sel_size_s  = bus.lsu_arb_arsize;
      sel_burst_s = bus.lsu_arb_arburst;
    end
  end

  // R-channel ownership and beat acceptance; nothing is accepted outside DATA.
  always_comb begin
    own_lsu_s = (state_r == ST_DATA) && (owner_r == OWN_LSU);
    own_ifu_s = (state_r == ST_DATA) && (owner_r == OWN_IFU);
    if (own_lsu_s) begin
      rrdy_s = bus.lsu_arb_rrdy;
    end else if (own_ifu_s) begin
      rrdy_s = bus.ifu_arb_rrdy;
    end else begin
      rrdy_s = 1'b0;
    end
    beat_acc_s = bus.axi_arb_rvld && rrdy_s;
    beat_nxt_s = beat_cnt_r + 9'd1;
  end

  assign bus.arb_lsu_arrdy   = gnt_lsu_s;
  assign bus.arb_ifu_arrdy   = gnt_ifu_s;
  assign bus.arb_axi_rrdy    = rrdy_s;
  assign bus.arb_lsu_rvld    = own_lsu_s && bus.axi_arb_rvld;
  assign bus.arb_lsu_rdata   = own_lsu_s ? bus.axi_arb_rdata : 64'd0;
  assign bus.arb_lsu_rresp   = own_lsu_s ? bus.axi_arb_rresp : 2'd0;
  assign bus.arb_lsu_rlast   = own_lsu_s && bus.axi_arb_rlast;
  assign bus.arb_lsu_rid     = own_lsu_s ? bus.axi_arb_rid : 8'd0;
  assign bus.arb_ifu_rvld    = own_ifu_s && bus.axi_arb_rvld;
  assign bus.arb_ifu_rdata   = own_ifu_s ? bus.axi_arb_rdata : 64'd0;
  assign bus.arb_ifu_rresp   = own_ifu_s ? bus.axi_arb_rresp : 2'd0;
  assign bus.arb_ifu_rlast   = own_ifu_s && bus.axi_arb_rlast;
  assign bus.arb_ifu_rid     = own_ifu_s ? bus.axi_arb_rid : 8'd0;
  assign bus.arb_axi_arvld   = arvld_r;
  assign bus.arb_axi_arid    = arid_r;
  assign bus.arb_axi_araddr  = araddr_r;
  assign bus.arb_axi_arlen   = arlen_r;
  assign bus.arb_axi_arsize  = arsize_r;
  assign bus.arb_axi_arburst = arburst_r;
  assign bus.arb_busy        = (state_r != ST_IDLE);
  assign bus.arb_len_err     = len_err_r;

  // Burst FSM: grant, hold AR until accepted, count beats until rlast.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      owner_r    <= OWN_LSU;
      beat_cnt_r <= 9'd0;
      len_err_r  <= 1'b0;
      arvld_r    <= 1'b0;
      arid_r     <= 8'd0;
      araddr_r   <= '0;
      arlen_r    <= 8'd0;
      arsize_r   <= 3'd0;
      arburst_r  <= 2'd0;
`ifndef DRAM_RD_ARB_LSU_PRIO_EN
      last_gnt_r <= OWN_IFU;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (gnt_lsu_s || gnt_ifu_s) begin
            owner_r    <= gnt_ifu_s ? OWN_IFU : OWN_LSU;
            arvld_r    <= 1'b1;
            arid_r     <= sel_id_s;
            araddr_r   <= sel_addr_s;
            arlen_r    <= sel_len_s;
            arsize_r   <= sel_size_s;
            arburst_r  <= sel_burst_s;
            beat_cnt_r <= 9'd0;
            state_r    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (bus.axi_arb_arrdy) begin
            arvld_r <= 1'b0;
            state_r <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat_acc_s) begin
            beat_cnt_r <= beat_nxt_s;
            if (bus.axi_arb_rlast) begin
              // arlen_r stays valid through DATA, so it doubles as the expected length.
              if (beat_nxt_s != ({1'b0, arlen_r} + 9'd1)) begin
                len_err_r <= 1'b1;
              end
`ifndef DRAM_RD_ARB_LSU_PRIO_EN
              last_gnt_r <= owner_r;
`endif
              state_r <= ST_IDLE;
            end
          end
        end
        default: begin
          arvld_r <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dram_rd_arb.sv
// Directed bench for dram_rd_arb: transaction-level reference model compared every cycle,
// plus literal expectations for each scenario.
module tb_dram_rd_arb;
  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  dram_rd_arb_if #(.ADDR_W(ADDR_W)) bus ();
  dram_rd_arb #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] beat_val(input logic [7:0] id, input int idx);
    return {8'hD0, 24'h0, id, 16'h0, 8'(idx)};
  endfunction

  // ---------------- reference model (transaction level) ----------------
  bit                m_busy = 1'b0;
  bit                m_addr = 1'b0;
  bit                m_owner = 1'b0;   // 0 = LSU, 1 = IFU
  bit                m_prev = 1'b1;    // last requester to finish a burst
  bit                m_err = 1'b0;
  int                m_beats = 0;
  logic [7:0]        m_id = 8'd0;
  logic [ADDR_W-1:0] m_ad = '0;
  logic [7:0]        m_len = 8'd0;
  logic [2:0]        m_size = 3'd0;
  logic [1:0]        m_burst = 2'd0;

  function automatic bit lsu_wins(input bit lv, input bit iv);
`ifdef DRAM_RD_ARB_LSU_PRIO_EN
    return lv || (iv && 1'b0);
`else
    return lv && (!iv || m_prev);
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_addr <= 1'b0; m_owner <= 1'b0; m_prev <= 1'b1; m_err <= 1'b0;
      m_beats <= 0; m_id <= 8'd0; m_ad <= '0; m_len <= 8'd0; m_size <= 3'd0; m_burst <= 2'd0;
    end else if (!m_busy) begin
      if (bus.lsu_arb_arvld || bus.ifu_arb_arvld) begin
        if (lsu_wins(bus.lsu_arb_arvld, bus.ifu_arb_arvld)) begin
          m_owner <= 1'b0; m_id <= bus.lsu_arb_arid; m_ad <= bus.lsu_arb_araddr;
          m_len <= bus.lsu_arb_arlen; m_size <= bus.lsu_arb_arsize; m_burst <= bus.lsu_arb_arburst;
        end else begin
          m_owner <= 1'b1; m_id <= bus.ifu_arb_arid; m_ad <= bus.ifu_arb_araddr;
          m_len <= bus.ifu_arb_arlen; m_size <= bus.ifu_arb_arsize; m_burst <= bus.ifu_arb_arburst;
        end
        m_busy <= 1'b1; m_addr <= 1'b1; m_beats <= 0;
      end
    end else if (m_addr) begin
      if (bus.axi_arb_arrdy) m_addr <= 1'b0;
    end else if (bus.axi_arb_rvld && (m_owner ? bus.ifu_arb_rrdy : bus.lsu_arb_rrdy)) begin
      m_beats <= m_beats + 1;
      if (bus.axi_arb_rlast) begin
        if (m_beats + 1 != int'(m_len) + 1) m_err <= 1'b1;
        m_busy <= 1'b0;
        m_prev <= m_owner;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit e_lg, e_ig, e_data, e_rrdy, e_lrv, e_irv;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_lsu_arrdy", bus.arb_lsu_arrdy, 1'b0);
      chk("rst_ifu_arrdy", bus.arb_ifu_arrdy, 1'b0);
      chk("rst_axi_arvld", bus.arb_axi_arvld, 1'b0);
      chk("rst_axi_rrdy", bus.arb_axi_rrdy, 1'b0);
      chk("rst_rvld", {bus.arb_lsu_rvld, bus.arb_ifu_rvld}, 2'b00);
      chk("rst_payload", {bus.arb_axi_arid, bus.arb_axi_araddr, bus.arb_axi_arlen,
                          bus.arb_axi_arsize, bus.arb_axi_arburst}, 64'd0);
      chk("rst_busy_err", {bus.arb_busy, bus.arb_len_err}, 2'b00);
    end else begin
      e_lg   = !m_busy && lsu_wins(bus.lsu_arb_arvld, bus.ifu_arb_arvld);
      e_ig   = !m_busy && bus.ifu_arb_arvld && !lsu_wins(bus.lsu_arb_arvld, bus.ifu_arb_arvld);
      e_data = m_busy && !m_addr;
      e_rrdy = e_data && (m_owner ? bus.ifu_arb_rrdy : bus.lsu_arb_rrdy);
      e_lrv  = e_data && !m_owner && bus.axi_arb_rvld;
      e_irv  = e_data && m_owner && bus.axi_arb_rvld;
      chk("lsu_arrdy", bus.arb_lsu_arrdy, e_lg);
      chk("ifu_arrdy", bus.arb_ifu_arrdy, e_ig);
      chk("axi_arvld", bus.arb_axi_arvld, m_busy && m_addr);
      if (m_busy && m_addr)
        chk("axi_ar_payload",
            {bus.arb_axi_arid, bus.arb_axi_araddr, bus.arb_axi_arlen, bus.arb_axi_arsize, bus.arb_axi_arburst},
            {m_id, m_ad, m_len, m_size, m_burst});
      chk("axi_rrdy", bus.arb_axi_rrdy, e_rrdy);
      chk("lsu_rvld", bus.arb_lsu_rvld, e_lrv);
      chk("ifu_rvld", bus.arb_ifu_rvld, e_irv);
      if (e_lrv) begin
        chk("lsu_rdata", bus.arb_lsu_rdata, bus.axi_arb_rdata);
        chk("lsu_rmeta", {bus.arb_lsu_rresp, bus.arb_lsu_rlast, bus.arb_lsu_rid},
            {bus.axi_arb_rresp, bus.axi_arb_rlast, bus.axi_arb_rid});
      end
      if (e_irv) begin
        chk("ifu_rdata", bus.arb_ifu_rdata, bus.axi_arb_rdata);
        chk("ifu_rmeta", {bus.arb_ifu_rresp, bus.arb_ifu_rlast, bus.arb_ifu_rid},
            {bus.axi_arb_rresp, bus.axi_arb_rlast, bus.axi_arb_rid});
      end
      chk("busy", bus.arb_busy, m_busy);
      chk("len_err", bus.arb_len_err, m_err);
    end
  end

  // ---------------- stimulus: requesters and AXI slave ----------------
  int          ar_delay = 0;
  int          ar_cnt = 0;
  int          ar_high = 0;
  int          r_override = -1;
  bit          r_active = 1'b0;
  int          r_total = 0;
  int          r_idx = 0;
  logic [7:0]  r_id = 8'd0;
  bit          toggle_ifu_rrdy = 1'b0;
  bit          grant_log[$];
  logic [63:0] lsu_got[$];
  logic [63:0] ifu_got[$];

  task automatic drive_r();
    bus.axi_arb_rvld  = r_active;
    bus.axi_arb_rdata = r_active ? beat_val(r_id, r_idx) : 64'd0;
    bus.axi_arb_rresp = r_active ? 2'(r_idx) : 2'd0;
    bus.axi_arb_rlast = r_active && (r_idx == r_total - 1);
    bus.axi_arb_rid   = r_active ? r_id : 8'd0;
  endtask

  task automatic req(input bit ifu, input logic [7:0] id, input logic [ADDR_W-1:0] addr, input logic [7:0] len);
    if (ifu) begin
      bus.ifu_arb_arvld = 1'b1; bus.ifu_arb_arid = id; bus.ifu_arb_araddr = addr;
      bus.ifu_arb_arlen = len; bus.ifu_arb_arsize = 3'd3; bus.ifu_arb_arburst = 2'd1;
    end else begin
      bus.lsu_arb_arvld = 1'b1; bus.lsu_arb_arid = id; bus.lsu_arb_araddr = addr;
      bus.lsu_arb_arlen = len; bus.lsu_arb_arsize = 3'd3; bus.lsu_arb_arburst = 2'd1;
    end
  endtask

  // One clock: sample handshakes at negedge, update drivers just after posedge.
  task automatic step();
    bit l_hs, i_hs, ar_hs, r_hs;
    logic [7:0] hs_len, hs_id;
    @(negedge clk);
    l_hs   = bus.arb_lsu_arrdy && bus.lsu_arb_arvld;
    i_hs   = bus.arb_ifu_arrdy && bus.ifu_arb_arvld;
    ar_hs  = bus.arb_axi_arvld && bus.axi_arb_arrdy;
    r_hs   = bus.axi_arb_rvld && bus.arb_axi_rrdy;
    hs_len = bus.arb_axi_arlen;
    hs_id  = bus.arb_axi_arid;
    if (bus.arb_axi_arvld) ar_high++;
    if (bus.arb_lsu_rvld && bus.lsu_arb_rrdy) lsu_got.push_back(bus.arb_lsu_rdata);
    if (bus.arb_ifu_rvld && bus.ifu_arb_rrdy) ifu_got.push_back(bus.arb_ifu_rdata);
    if (l_hs) grant_log.push_back(1'b0);
    if (i_hs) grant_log.push_back(1'b1);
    @(posedge clk);
    #1;
    if (l_hs) bus.lsu_arb_arvld = 1'b0;
    if (i_hs) bus.ifu_arb_arvld = 1'b0;
    if (toggle_ifu_rrdy) bus.ifu_arb_rrdy = !bus.ifu_arb_rrdy;
    if (r_hs) begin
      r_idx++;
      if (r_idx == r_total) r_active = 1'b0;
    end
    if (ar_hs) begin
      r_active = 1'b1;
      r_idx    = 0;
      r_total  = (r_override >= 0) ? r_override : int'(hs_len) + 1;
      r_id     = hs_id;
    end
    drive_r();
    if (bus.arb_axi_arvld) begin
      bus.axi_arb_arrdy = (ar_cnt >= ar_delay);
      ar_cnt++;
    end else begin
      bus.axi_arb_arrdy = (ar_delay == 0);
      ar_cnt = 0;
    end
    #1;
  endtask

  task automatic run_idle(input int budget, input string name);
    int n = 0;
    while ((bus.arb_busy || bus.lsu_arb_arvld || bus.ifu_arb_arvld || r_active) && n < budget) begin
      step();
      n++;
    end
    chk({name, "_completed"}, (n < budget), 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.lsu_arb_arvld = 1'b0;
    bus.ifu_arb_arvld = 1'b0;
    r_active = 1'b0;
    drive_r();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1);
  end

  bit exp_order[3];
  int n;
  bit reraised;

  initial begin
    bus.lsu_arb_arvld = 1'b0; bus.lsu_arb_arid = 8'd0; bus.lsu_arb_araddr = '0;
    bus.lsu_arb_arlen = 8'd0; bus.lsu_arb_arsize = 3'd0; bus.lsu_arb_arburst = 2'd0;
    bus.ifu_arb_arvld = 1'b0; bus.ifu_arb_arid = 8'd0; bus.ifu_arb_araddr = '0;
    bus.ifu_arb_arlen = 8'd0; bus.ifu_arb_arsize = 3'd0; bus.ifu_arb_arburst = 2'd0;
    bus.lsu_arb_rrdy = 1'b1; bus.ifu_arb_rrdy = 1'b1; bus.axi_arb_arrdy = 1'b1;
    drive_r();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", bus.arb_busy, 1'b0);
    chk("reset_len_err", bus.arb_len_err, 1'b0);
    chk("reset_araddr", bus.arb_axi_araddr, 10'h000);
    rst_n = 1'b1;
    #1;

    // Single LSU burst, len 3.
    req(1'b0, 8'h11, 10'h040, 8'd3);
    #1 chk("t1_lsu_arrdy_c0", bus.arb_lsu_arrdy, 1'b1);
    step();
    chk("t1_axi_arvld_c1", bus.arb_axi_arvld, 1'b1);
    chk("t1_araddr_c1", bus.arb_axi_araddr, 10'h040);
    run_idle(40, "t1");
    chk("t1_lsu_beats", lsu_got.size(), 4);
    for (int i = 0; i < 4 && i < lsu_got.size(); i++) chk("t1_lsu_data", lsu_got[i], beat_val(8'h11, i));
    chk("t1_ifu_beats", ifu_got.size(), 0);
    chk("t1_busy_end", bus.arb_busy, 1'b0);
    chk("t1_len_err", bus.arb_len_err, 1'b0);

    // Tie from reset, LSU re-requests after its first grant.
    do_reset();
    lsu_got.delete(); ifu_got.delete(); grant_log.delete();
    req(1'b0, 8'h21, 10'h100, 8'd0);
    req(1'b1, 8'h31, 10'h200, 8'd0);
    #1;
    chk("t2_lsu_first", bus.arb_lsu_arrdy, 1'b1);
    chk("t2_ifu_waits", bus.arb_ifu_arrdy, 1'b0);
    n = 0; reraised = 1'b0;
    while ((bus.arb_busy || bus.lsu_arb_arvld || bus.ifu_arb_arvld || r_active || !reraised) && n < 60) begin
      step();
      n++;
      if (!reraised && grant_log.size() == 1) begin
        req(1'b0, 8'h22, 10'h108, 8'd0);
        reraised = 1'b1;
      end
    end
    chk("t2_completed", (n < 60), 1'b1);
`ifdef DRAM_RD_ARB_LSU_PRIO_EN
    exp_order[0] = 1'b0; exp_order[1] = 1'b0; exp_order[2] = 1'b1;
`else
    exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0;
`endif
    chk("t2_grant_count", grant_log.size(), 3);
    for (int i = 0; i < 3 && i < grant_log.size(); i++) chk("t2_grant_order", grant_log[i], exp_order[i]);
    chk("t2_ifu_beats", ifu_got.size(), 1);
    if (ifu_got.size() > 0) chk("t2_ifu_data", ifu_got[0], beat_val(8'h31, 0));
    chk("t2_lsu_beats", lsu_got.size(), 2);

    // AR held off for 5 cycles.
    ar_delay = 5; ar_high = 0;
    req(1'b1, 8'h41, 10'h3FC, 8'd0);
    run_idle(40, "t3");
    ar_delay = 0;
    chk("t3_arvld_cycles", ar_high, 6);

    // len=1 but slave sends 3 beats: sticky length error.
    r_override = 3; lsu_got.delete();
    req(1'b0, 8'h51, 10'h010, 8'd1);
    run_idle(40, "t4a");
    r_override = -1;
    chk("t4_lsu_beats", lsu_got.size(), 3);
    chk("t4_len_err_set", bus.arb_len_err, 1'b1);
    chk("t4_idle", bus.arb_busy, 1'b0);
    req(1'b1, 8'h52, 10'h018, 8'd0);
    run_idle(40, "t4b");
    chk("t4_len_err_sticky", bus.arb_len_err, 1'b1);

    // IFU owner with toggling rrdy; LSU pulses a request that it withdraws mid-burst.
    lsu_got.delete(); ifu_got.delete(); grant_log.delete();
    toggle_ifu_rrdy = 1'b1;
    req(1'b1, 8'h61, 10'h020, 8'd3);
    n = 0;
    while ((bus.arb_busy || bus.lsu_arb_arvld || bus.ifu_arb_arvld || r_active) && n < 60) begin
      step();
      n++;
      if (n == 2) req(1'b0, 8'h62, 10'h028, 8'd0);
      if (n == 4) bus.lsu_arb_arvld = 1'b0;
    end
    toggle_ifu_rrdy = 1'b0;
    bus.ifu_arb_rrdy = 1'b1;
    chk("t5_completed", (n < 60), 1'b1);
    chk("t5_ifu_beats", ifu_got.size(), 4);
    for (int i = 0; i < 4 && i < ifu_got.size(); i++) chk("t5_ifu_data", ifu_got[i], beat_val(8'h61, i));
    chk("t5_lsu_beats", lsu_got.size(), 0);
    chk("t5_grant_count", grant_log.size(), 1);

    // Reset during beat 2, then a fresh LSU request.
    lsu_got.delete();
    req(1'b0, 8'h71, 10'h040, 8'd3);
    n = 0;
    while (lsu_got.size() < 1 && n < 40) begin
      step();
      n++;
    end
    chk("t6_reached_beat2", (n < 40), 1'b1);
    rst_n = 1'b0;
    req(1'b0, 8'h72, 10'h080, 8'd1);
    #1;
    chk("t6_rst_busy", bus.arb_busy, 1'b0);
    chk("t6_rst_arvld", bus.arb_axi_arvld, 1'b0);
    chk("t6_rst_rrdy", bus.arb_axi_rrdy, 1'b0);
    chk("t6_rst_lsu_rvld", bus.arb_lsu_rvld, 1'b0);
    chk("t6_rst_lsu_rdata", bus.arb_lsu_rdata, 64'd0);
    chk("t6_rst_lsu_arrdy", bus.arb_lsu_arrdy, 1'b0);
    chk("t6_rst_len_err", bus.arb_len_err, 1'b0);
    chk("t6_rst_araddr", bus.arb_axi_araddr, 10'h000);
    r_active = 1'b0;
    drive_r();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    lsu_got.delete();
    run_idle(40, "t6");
    chk("t6_lsu_beats", lsu_got.size(), 2);
    for (int i = 0; i < 2 && i < lsu_got.size(); i++) chk("t6_lsu_data", lsu_got[i], beat_val(8'h72, i));
    chk("t6_len_err", bus.arb_len_err, 1'b0);

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
